pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000, address loaded on reset.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port phase  input  1  1 = fetch cycle, 0 = execute cycle (from phase toggler).
REQ-005 SHALL have port instruction  input  4  opcode nibble latched by fetch stage.
REQ-006 SHALL have port operand  input  4  immediate nibble latched by fetch stage; high nibble of jump target.
REQ-007 SHALL have port target_lo  input  8  low byte of jump target.
REQ-008 SHALL have port carry  input  1  ALU carry flag.
REQ-009 SHALL have port zero  input  1  ALU zero flag.
REQ-010 SHALL have port pc  output  12  program address driven to ROM.
REQ-011 SHALL have port taken  output  1  registered; high for the cycle after a taken branch.
REQ-012 SHALL have port stack_err  output  1  sticky call-stack overflow/underflow flag (CALL_STACK_EN only; otherwise tied 0).

Function
REQ-013 SHALL hold pc and clear taken on every edge where phase=1.
REQ-014 SHALL update pc only on edges where phase=0 (end of execute).
REQ-015 SHALL decode: 1000 JC (carry=1), 1001 JNC (carry=0), 1010 JZ (zero=1), 1011 JNZ (zero=0), 1100 JMP (always).
REQ-016 SHALL load pc <= {operand, target_lo} and set taken=1 when the decoded condition is true.
REQ-017 SHALL otherwise load pc <= pc+1 and set taken=0; all other opcodes are non-branching.
REQ-018 SHALL wrap increment modulo 4096: 12'hFFF -> 12'h000, no flag.
REQ-019 SHALL treat a branch targeting its own address as legal (pc unchanged, taken=1).
REQ-020 SHALL make pc visible to ROM with zero combinational path from inputs (pc is a register).
REQ-021 SHALL give reset priority over phase, branch, and stack activity in the same cycle.

Reset
REQ-022 SHALL, on a rising edge with reset=0, set pc=RESET_PC, taken=0, stack depth=0, stack_err=0.
REQ-023 SHALL abandon any pending branch or call when reset is asserted mid-execute; no partial update survives.
REQ-024 SHALL resume normal sequencing on the first edge with reset=1.

Configuration
REQ-025 SHALL compile a 4-entry return stack when macro PC_SEQUENCER_CALL_STACK_EN is defined.
REQ-026 With macro: opcode 1101 CALL pushes pc+1 (wrapped) and jumps to {operand, target_lo}, taken=1.
REQ-027 With macro: opcode 1110 RET pops the top entry into pc, taken=1.
REQ-028 With macro: CALL at depth 4 leaves stack unchanged, still jumps, sets stack_err; RET at depth 0 does pc+1, sets stack_err.
REQ-029 stack_err SHALL stay set until reset.
REQ-030 Without macro: 1101/1110 are non-branching (pc+1), no stack storage, stack_err constant 0.

Verification
REQ-031 reset=0 for 2 edges, then reset=1, phase toggling, opcode 0000 -> pc 000,000,001,001,002 (one step per execute).
REQ-032 pc=12'h0FE, execute JZ, operand=4'h3, target_lo=8'h40, zero=1 -> pc=12'h340, taken=1 next cycle; zero=0 -> pc=12'h0FF, taken=0.
REQ-033 pc=12'hFFF, execute opcode 0000 -> pc=12'h000, taken=0.
REQ-034 JMP in execute with reset=0 on same edge -> pc=RESET_PC, taken=0.
REQ-035 With PC_SEQUENCER_CALL_STACK_EN: CALL at pc=12'h010 to 12'h200, then RET -> pc 12'h200 then 12'h011; fifth nested CALL -> stack_err=1.
REQ-036 Without macro: opcode 1101 at pc=12'h010 -> pc=12'h011, taken=0, stack_err=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: 12-bit program counter for a two-phase (fetch/execute) CPU.
// The PC advances or branches only at the end of an execute cycle; fetch
// edges hold it. Conditional jumps test the ALU carry/zero flags.
// Optional feature: define PC_SEQUENCER_CALL_STACK_EN to build a 4-entry
// return stack with CALL (1101) / RET (1110) and a sticky stack_err flag.
// Without the macro those opcodes fall through as plain increments.
module pc_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phase,
  input  logic [3:0]  instruction,
  input  logic [3:0]  operand,
  input  logic [7:0]  target_lo,
  input  logic        carry,
  input  logic        zero,
  output logic [11:0] pc,
  output logic        taken,
  output logic        stack_err
);

  localparam logic [3:0] OP_JC   = 4'b1000;
  localparam logic [3:0] OP_JNC  = 4'b1001;
  localparam logic [3:0] OP_JZ   = 4'b1010;
  localparam logic [3:0] OP_JNZ  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
`ifdef PC_SEQUENCER_CALL_STACK_EN
  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;
`endif

  logic [11:0] r_pc;
  logic        r_taken;

  logic [11:0] w_pc_inc;
  logic [11:0] w_target;
  logic [11:0] w_next_pc;
  logic        w_next_taken;

  // Increment wraps naturally modulo 4096; target is the concatenated jump field.
  assign w_pc_inc = r_pc + 12'd1;
  assign w_target = {operand, target_lo};

`ifdef PC_SEQUENCER_CALL_STACK_EN
  logic [11:0] r_stack [0:3];
  logic [2:0]  r_depth;
  logic        r_stack_err;
  logic        w_push;
  logic        w_pop;
  logic        w_err_set;
  logic [1:0]  w_top_idx;

  // Index of the most recent entry; only meaningful when depth is 1..4.
  assign w_top_idx = r_depth[1:0] - 2'd1;
`endif

  // Decode the execute-cycle opcode into next PC, taken flag and stack actions.
  always_comb begin
    w_next_pc    = w_pc_inc;
    w_next_taken = 1'b0;
`ifdef PC_SEQUENCER_CALL_STACK_EN
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_err_set    = 1'b0;
`endif
    case (instruction)
      OP_JC: begin
        if (carry) begin
          w_next_pc    = w_target;
          w_next_taken = 1'b1;
        end else begin
          w_next_pc    = w_pc_inc;
          w_next_taken = 1'b0;
        end
      end
      OP_JNC: begin
        if (!carry) begin
          w_next_pc    = w_target;
          w_next_taken = 1'b1;
        end else begin
          w_next_pc    = w_pc_inc;
          w_next_taken = 1'b0;
        end
      end
      OP_JZ: begin
        if (zero) begin
          w_next_pc    = w_target;
          w_next_taken = 1'b1;
        end else begin
          w_next_pc    = w_pc_inc;
          w_next_taken = 1'b0;
        end
      end
      OP_JNZ: begin
        if (!zero) begin
          w_next_pc    = w_target;
          w_next_taken = 1'b1;
        end else begin
          w_next_pc    = w_pc_inc;
          w_next_taken = 1'b0;
        end
      end
      OP_JMP: begin
        w_next_pc    = w_target;
        w_next_taken = 1'b1;
      end
`ifdef PC_SEQUENCER_CALL_STACK_EN
      OP_CALL: begin
        // A full stack still jumps; the return address is simply lost.
        w_next_pc    = w_target;
        w_next_taken = 1'b1;
        if (r_depth == 3'd4) begin
          w_err_set = 1'b1;
        end else begin
          w_push = 1'b1;
        end
      end
      OP_RET: begin
        // An empty stack degrades to a plain increment.
        if (r_depth == 3'd0) begin
          w_err_set    = 1'b1;
          w_next_pc    = w_pc_inc;
          w_next_taken = 1'b0;
        end else begin
          w_pop        = 1'b1;
          w_next_pc    = r_stack[w_top_idx];
          w_next_taken = 1'b1;
        end
      end
`endif
      default: begin
        w_next_pc    = w_pc_inc;
        w_next_taken = 1'b0;
      end
    endcase
  end

  // PC/taken/stack-control register: reset first, fetch holds, execute commits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_taken     <= 1'b0;
`ifdef PC_SEQUENCER_CALL_STACK_EN
      r_depth     <= 3'd0;
      r_stack_err <= 1'b0;
`endif
    end else if (phase) begin
      r_pc    <= r_pc;
      r_taken <= 1'b0;
    end else begin
      r_pc    <= w_next_pc;
      r_taken <= w_next_taken;
`ifdef PC_SEQUENCER_CALL_STACK_EN
      if (w_push) begin
        r_depth <= r_depth + 3'd1;
      end else if (w_pop) begin
        r_depth <= r_depth - 3'd1;
      end else begin
        r_depth <= r_depth;
      end
      if (w_err_set) begin
        r_stack_err <= 1'b1;
      end else begin
        r_stack_err <= r_stack_err;
      end
`endif
    end
  end

`ifdef PC_SEQUENCER_CALL_STACK_EN
  // Return-address storage; contents are don't-care until written, depth guards reads.
  always_ff @(posedge clk) begin
    if (reset && !phase && w_push) begin
      r_stack[r_depth[1:0]] <= w_pc_inc;
    end else begin
      r_stack[r_depth[1:0]] <= r_stack[r_depth[1:0]];
    end
  end

  assign stack_err = r_stack_err;
`else
  assign stack_err = 1'b0;
`endif

  assign pc    = r_pc;
  assign taken = r_taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. Each clock step computes the
// expected pc/taken/stack_err from a behavioural model, queues it, and
// compares it against the DUT one time unit after the rising edge.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        phase;
  logic [3:0]  instruction;
  logic [3:0]  operand;
  logic [7:0]  target_lo;
  logic        carry;
  logic        zero;
  logic [11:0] pc;
  logic        taken;
  logic        stack_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [11:0] pc;
    logic        taken;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model state
  logic [11:0] m_pc;
  logic        m_taken;
  logic        m_err;
  logic [11:0] m_stack [0:3];
  int          m_depth;

  pc_sequencer #(.RESET_PC(12'h000)) dut (
    .clk         (clk),
    .reset       (reset),
    .phase       (phase),
    .instruction (instruction),
    .operand     (operand),
    .target_lo   (target_lo),
    .carry       (carry),
    .zero        (zero),
    .pc          (pc),
    .taken       (taken),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Model of one clock edge, derived directly from the opcode table.
  task automatic model_edge(input logic ph, input logic [3:0] ins, input logic [3:0] op,
                            input logic [7:0] tlo, input logic c, input logic z,
                            input logic rst);
    logic [11:0] tgt;
    logic [11:0] inc;
    logic        cond;
    tgt = {op, tlo};
    inc = m_pc + 12'd1;
    if (!rst) begin
      m_pc = 12'h000; m_taken = 1'b0; m_err = 1'b0; m_depth = 0;
    end else if (ph) begin
      m_taken = 1'b0;
    end else begin
      cond = (ins == 4'b1000 && c) || (ins == 4'b1001 && !c) ||
             (ins == 4'b1010 && z) || (ins == 4'b1011 && !z) || (ins == 4'b1100);
`ifdef PC_SEQUENCER_CALL_STACK_EN
      if (ins == 4'b1101) begin
        if (m_depth == 4) m_err = 1'b1;
        else begin m_stack[m_depth] = inc; m_depth++; end
        m_pc = tgt; m_taken = 1'b1;
      end else if (ins == 4'b1110) begin
        if (m_depth == 0) begin
          m_err = 1'b1; m_pc = inc; m_taken = 1'b0;
        end else begin
          m_depth--; m_pc = m_stack[m_depth]; m_taken = 1'b1;
        end
      end else
`endif
      if (cond) begin
        m_pc = tgt; m_taken = 1'b1;
      end else begin
        m_pc = inc; m_taken = 1'b0;
      end
    end
  endtask

  // Drive one edge, queue the model's prediction, then compare the DUT.
  task automatic step(input string tag, input logic ph, input logic [3:0] ins,
                      input logic [3:0] op, input logic [7:0] tlo,
                      input logic c, input logic z, input logic rst);
    exp_t e;
    @(negedge clk);
    phase = ph; instruction = ins; operand = op; target_lo = tlo;
    carry = c; zero = z; reset = rst;
    model_edge(ph, ins, op, tlo, c, z, rst);
    exp_q.push_back({m_pc, m_taken, m_err});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val({tag, ".pc"}, {20'd0, pc}, {20'd0, e.pc});
    check_val({tag, ".taken"}, {31'd0, taken}, {31'd0, e.taken});
    check_val({tag, ".err"}, {31'd0, stack_err}, {31'd0, e.err});
  endtask

  // One instruction: a fetch edge followed by an execute edge.
  task automatic exec(input string tag, input logic [3:0] ins, input logic [3:0] op,
                      input logic [7:0] tlo, input logic c, input logic z);
    step({tag, ".f"}, 1'b1, ins, op, tlo, c, z, 1'b1);
    step({tag, ".x"}, 1'b0, ins, op, tlo, c, z, 1'b1);
  endtask

  task automatic jump_to(input logic [11:0] a);
    exec("jmp", 4'b1100, a[11:8], a[7:0], 1'b0, 1'b0);
  endtask

  initial begin
    m_pc = 12'h000; m_taken = 1'b0; m_err = 1'b0; m_depth = 0;
    reset = 1'b0; phase = 1'b1; instruction = 4'h0; operand = 4'h0;
    target_lo = 8'h00; carry = 1'b0; zero = 1'b0;

    // Reset for two edges, then sequential counting
    step("rst0", 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    step("rst1", 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_val("rst.pc_const", {20'd0, pc}, 32'h000);
    step("seq0", 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("seq1", 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("seq.pc1", {20'd0, pc}, 32'h001);
    step("seq2", 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("seq3", 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("seq.pc2", {20'd0, pc}, 32'h002);

    // JZ from 0FE, taken and not taken
    jump_to(12'h0FE);
    exec("jz_t", 4'b1010, 4'h3, 8'h40, 1'b0, 1'b1);
    check_val("jz_t.pc_const", {20'd0, pc}, 32'h340);
    check_val("jz_t.taken_const", {31'd0, taken}, 32'd1);
    step("jz_t.clr", 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("jz_t.cleared", {31'd0, taken}, 32'd0);
    jump_to(12'h0FE);
    exec("jz_n", 4'b1010, 4'h3, 8'h40, 1'b0, 1'b0);
    check_val("jz_n.pc_const", {20'd0, pc}, 32'h0FF);

    // Wrap at top of address space
    jump_to(12'hFFF);
    exec("wrap", 4'b0000, 4'h0, 8'h00, 1'b0, 1'b0);
    check_val("wrap.pc_const", {20'd0, pc}, 32'h000);

    // Reset wins over a JMP on the same execute edge
    jump_to(12'h5A5);
    step("rjmp.f", 1'b1, 4'b1100, 4'h7, 8'h77, 1'b0, 1'b0, 1'b1);
    step("rjmp.x", 1'b0, 4'b1100, 4'h7, 8'h77, 1'b0, 1'b0, 1'b0);
    check_val("rjmp.pc_const", {20'd0, pc}, 32'h000);
    step("rjmp.resume", 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Branch to own address
    jump_to(12'h123);
    exec("self", 4'b1100, 4'h1, 8'h23, 1'b0, 1'b0);
    check_val("self.pc_const", {20'd0, pc}, 32'h123);

    // Sweep every opcode against every flag combination
    for (int o = 0; o < 16; o++) begin
      for (int f = 0; f < 4; f++) begin
        logic [11:0] t;
        logic [3:0]  ov;
        logic [1:0]  fv;
        t  = 12'($urandom_range(0, 4095));
        ov = 4'(o);
        fv = 2'(f);
        exec("sweep", ov, t[11:8], t[7:0], fv[0], fv[1]);
      end
    end

    // Fresh reset before the call/return scenario
    step("rst2", 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    jump_to(12'h010);
`ifdef PC_SEQUENCER_CALL_STACK_EN
    exec("call", 4'b1101, 4'h2, 8'h00, 1'b0, 1'b0);
    check_val("call.pc_const", {20'd0, pc}, 32'h200);
    exec("ret", 4'b1110, 4'h0, 8'h00, 1'b0, 1'b0);
    check_val("ret.pc_const", {20'd0, pc}, 32'h011);
    for (int k = 0; k < 5; k++) begin
      exec("nest", 4'b1101, 4'(k + 1), 8'h10, 1'b0, 1'b0);
    end
    check_val("ovf.err_const", {31'd0, stack_err}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      exec("unwind", 4'b1110, 4'h0, 8'h00, 1'b0, 1'b0);
    end
    check_val("err.sticky", {31'd0, stack_err}, 32'd1);
`else
    exec("call_off", 4'b1101, 4'h2, 8'h00, 1'b0, 1'b0);
    check_val("call_off.pc_const", {20'd0, pc}, 32'h011);
    check_val("call_off.err_const", {31'd0, stack_err}, 32'd0);
    exec("ret_off", 4'b1110, 4'h0, 8'h00, 1'b0, 1'b0);
`endif
    step("rst3", 1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_val("rst3.err_const", {31'd0, stack_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
